// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline sequencing controller
package pipeline_ctrl_pkg;

  localparam int          REG_AW    = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
  } ctrl_t;

  // Control patterns, field order pc_en/if_id_en/if_id_flush/id_ex_en/id_ex_flush
  localparam ctrl_t CTRL_OFF    = 5'b00000;
  localparam ctrl_t CTRL_RUN    = 5'b11010;
  localparam ctrl_t CTRL_FLUSH  = 5'b11111;
  localparam ctrl_t CTRL_BUBBLE = 5'b00011;
  localparam ctrl_t CTRL_DRAIN  = 5'b01110;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - pipeline controller signal bundle with cpu-side and controller-side views
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipeline_ctrl_pkg::*;

  logic              enable;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_redirect;
  logic              pc_en;
  logic              if_id_en;
  logic              if_id_flush;
  logic              id_ex_en;
  logic              id_ex_flush;
  logic              running;
  logic              halted;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output enable, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd, ex_redirect,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    input  running, halted, cycle_count, stall_count, flush_count
  );

  modport slave (
    input  enable, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd, ex_redirect,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    output running, halted, cycle_count, stall_count, flush_count
  );

endinterface

// File: rtl/pipe_hazard_detect.sv
// rtl/pipe_hazard_detect.sv - combinational load-use hazard detection between ID and EX
module pipe_hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_id_uses_rt,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rd,
  output logic              o_haz
);

  // $zero is never a real dependency, so a load targeting r0 never stalls
  assign o_haz = i_ex_mem_read & (i_ex_rd != '0) &
                 ((i_ex_rd == i_id_rs) | (i_id_uses_rt & (i_ex_rd == i_id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - run/stall/flush/drain sequencing of the PC and front pipeline registers
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  pipeline_ctrl_if.slave    bus
);

  localparam int              DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0]   DRAIN_ONE  = DW'(1);
  localparam logic [3:0]      STALL_LOAD = (STALL_CYCLES > 1) ? 4'(STALL_CYCLES - 2) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  logic [3:0]       r_stall_cnt;
  logic [DW-1:0]    r_drain_cnt;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;
  logic             w_haz;
  ctrl_t            w_ctrl;

  pipe_hazard_detect u_haz (
    .i_id_rs       (bus.id_rs),
    .i_id_rt       (bus.id_rt),
    .i_id_uses_rt  (bus.id_uses_rt),
    .i_ex_mem_read (bus.ex_mem_read),
    .i_ex_rd       (bus.ex_rd),
    .o_haz         (w_haz)
  );

  always_comb begin
    w_ctrl = CTRL_OFF;
    case (r_state)
      ST_RUN: begin
        if (bus.ex_redirect)  w_ctrl = CTRL_FLUSH;
        else if (w_haz)       w_ctrl = CTRL_BUBBLE;
        else                  w_ctrl = CTRL_RUN;
      end
      ST_STALL: w_ctrl = CTRL_BUBBLE;
      ST_DRAIN: w_ctrl = CTRL_DRAIN;
      default:  w_ctrl = CTRL_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state       <= ST_IDLE;
      r_stall_cnt   <= '0;
      r_drain_cnt   <= '0;
      r_cycle_count <= '0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (r_state != ST_IDLE) r_cycle_count <= r_cycle_count + CNT_ONE;
      case (r_state)
        ST_IDLE: begin
          if (bus.enable) begin
            r_state       <= ST_RUN;
            r_cycle_count <= '0;
            r_stall_count <= '0;
            r_flush_count <= '0;
          end
        end
        ST_RUN: begin
          // A redirect squashes the instruction that raised the hazard, so it wins
          if (bus.ex_redirect) begin
            r_flush_count <= r_flush_count + CNT_ONE;
            if (!bus.enable) begin
              r_state     <= ST_DRAIN;
              r_drain_cnt <= DRAIN_LOAD;
            end
          end else if (w_haz) begin
            r_stall_count <= r_stall_count + CNT_ONE;
            if (STALL_CYCLES > 1) begin
              r_state     <= ST_STALL;
              r_stall_cnt <= STALL_LOAD;
            end
          end else if (!bus.enable) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_STALL: begin
          r_stall_count <= r_stall_count + CNT_ONE;
          if (r_stall_cnt == 4'd0) begin
            if (bus.enable) begin
              r_state <= ST_RUN;
            end else begin
              r_state     <= ST_DRAIN;
              r_drain_cnt <= DRAIN_LOAD;
            end
          end else begin
            r_stall_cnt <= r_stall_cnt - 4'd1;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == '0) r_state     <= ST_IDLE;
          else                   r_drain_cnt <= r_drain_cnt - DRAIN_ONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pc_en       = w_ctrl.pc_en;
  assign bus.if_id_en    = w_ctrl.if_id_en;
  assign bus.if_id_flush = w_ctrl.if_id_flush;
  assign bus.id_ex_en    = w_ctrl.id_ex_en;
  assign bus.id_ex_flush = w_ctrl.id_ex_flush;
  assign bus.running     = (r_state == ST_RUN) || (r_state == ST_STALL);
  assign bus.halted      = (r_state == ST_IDLE);
  assign bus.cycle_count = r_cycle_count;
  assign bus.stall_count = r_stall_count;
  assign bus.flush_count = r_flush_count;

endmodule
